// File: rtl/led_tile_pkg.sv
// Shared scan-FSM state codes, readdata lane positions and width helpers for the LED tile driver.
// Pure declarations: no latency, no flow control.
package led_tile_pkg;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FETCH   = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_SCLK_LO = 3'd3;
   localparam logic [2:0] S_SCLK_HI = 3'd4;
   localparam logic [2:0] S_BLANK   = 3'd5;
   localparam logic [2:0] S_LATCH   = 3'd6;
   localparam logic [2:0] S_DISPLAY = 3'd7;

   // readdata[5:0] = {b2,g2,r2,b1,g1,r1}; upper bits carry nothing for the panel
   localparam int RGB_LSB = 0;
   localparam int RGB_MSB = 5;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic int width_of(input int n);
      return (n <= 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/led_tile_bcm_timer.sv
// BCM display-period down-counter: load in LATCH, expired after (BASE_TICKS << plane) cycles.
// Expired is a registered compare, so DISPLAY lasts exactly the loaded count; no backpressure.
module led_tile_bcm_timer
   import led_tile_pkg::*;
#(
   parameter  int BASE_TICKS = 64,
   parameter  int PLANES     = 4,
   localparam int PLANE_W    = width_of(PLANES),
   localparam int CNT_W      = width_of(BASE_TICKS << (PLANES - 1))
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               load,
   input  logic [PLANE_W-1:0] plane,
   output logic               expired
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Loading N-1 means the count reaches zero on the N-th cycle after load.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = CNT_W'((BASE_TICKS << plane) - 1);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/led_tile_scan_driver.sv
// HUB75 scan driver: Avalon-MM reads one pixel word per column, shifts it out, latches and BCM-displays each row.
// Column costs 4+ cycles; stalls in FETCH on waitrequest and in WAIT until readdatavalid (one read outstanding).
module led_tile_scan_driver
   import led_tile_pkg::*;
#(
   parameter  int COLS       = 32,
   parameter  int ROWS       = 16,
   parameter  int PLANES     = 4,
   parameter  int BASE_TICKS = 64,
   parameter  int ADDR_W     = 14,
   localparam int ROW_W      = width_of(ROWS)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic [ADDR_W-1:0] base_addr,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read,
   input  logic              mem_waitrequest,
   input  logic [15:0]       mem_readdata,
   input  logic              mem_readdatavalid,
   output logic [5:0]        led_rgb,
   output logic              led_clk,
   output logic              led_lat,
   output logic              led_oe_n,
   output logic [ROW_W-1:0]  led_row,
   output logic              frame_done
);

   localparam int COL_W   = width_of(COLS);
   localparam int PLANE_W = width_of(PLANES);

   typedef struct packed {
      logic [PLANE_W-1:0] plane;
      logic [ROW_W-1:0]   row;
      logic [COL_W-1:0]   col;
   } scan_pos_t;

   logic [2:0]        state_q, state_d;
   scan_pos_t         pos_q, pos_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [5:0]        rgb_q, rgb_d;
   logic [ROW_W-1:0]  row_out_q, row_out_d;
   logic              frame_done_q, frame_done_d;
   logic              tick_expired;
   logic              last_col, last_row, last_plane;
   logic [ADDR_W-1:0] offset;
   logic              unused_hi;

   assign unused_hi  = ^mem_readdata[15:RGB_MSB+1];
   assign last_col   = (pos_q.col   == COL_W'(COLS - 1));
   assign last_row   = (pos_q.row   == ROW_W'(ROWS - 1));
   assign last_plane = (pos_q.plane == PLANE_W'(PLANES - 1));

   // Linear word index of (plane,row,col); truncation gives the modulo-2^ADDR_W wrap.
   assign offset = ADDR_W'((32'(pos_q.plane) * ROWS + 32'(pos_q.row)) * COLS + 32'(pos_q.col));

   always_comb begin
      state_d      = state_q;
      pos_d        = pos_q;
      base_d       = base_q;
      rgb_d        = rgb_q;
      row_out_d    = row_out_q;
      frame_done_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (enable) begin
               base_d  = base_addr;
               pos_d   = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (!mem_waitrequest) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mem_readdatavalid) begin
               rgb_d   = mem_readdata[RGB_MSB:RGB_LSB];
               state_d = S_SCLK_LO;
            end
         end
         S_SCLK_LO: state_d = S_SCLK_HI;
         S_SCLK_HI: begin
            if (!last_col) begin
               pos_d.col = pos_q.col + COL_W'(1);
               state_d   = S_FETCH;
            end else begin
               state_d = S_BLANK;
            end
         end
         S_BLANK: begin
            row_out_d = pos_q.row;
            state_d   = S_LATCH;
         end
         S_LATCH: state_d = S_DISPLAY;
         S_DISPLAY: begin
            if (tick_expired) begin
               pos_d.col = '0;
               state_d   = S_FETCH;
               if (last_row && last_plane) begin
                  frame_done_d = 1'b1;
                  pos_d        = '0;
                  if (enable) base_d  = base_addr;
                  else        state_d = S_IDLE;
               end else if (last_row) begin
                  pos_d.row   = '0;
                  pos_d.plane = pos_q.plane + PLANE_W'(1);
               end else begin
                  pos_d.row = pos_q.row + ROW_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         pos_q        <= '0;
         base_q       <= '0;
         rgb_q        <= '0;
         row_out_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pos_q        <= pos_d;
         base_q       <= base_d;
         rgb_q        <= rgb_d;
         row_out_q    <= row_out_d;
         frame_done_q <= frame_done_d;
      end
   end

   led_tile_bcm_timer #(
      .BASE_TICKS(BASE_TICKS),
      .PLANES    (PLANES)
   ) u_bcm_timer (
      .clk    (clk),
      .reset_n(reset_n),
      .load   (state_q == S_LATCH),
      .plane  (pos_q.plane),
      .expired(tick_expired)
   );

   // Panel strobes decode straight from state so an async reset blanks the panel at once.
   assign mem_address = base_q + offset;
   assign mem_read    = (state_q == S_FETCH);
   assign led_clk     = (state_q == S_SCLK_HI);
   assign led_lat     = (state_q == S_LATCH);
   assign led_oe_n    = (state_q != S_DISPLAY);
   assign led_rgb     = rgb_q;
   assign led_row     = row_out_q;
   assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_led_tile_scan_driver.sv
// Bench for led_tile_scan_driver on a 4x2x2-plane tile: scoreboarded addresses, pixel data, row and BCM timing.
module tb_led_tile_scan_driver;

   localparam int COLS = 4, ROWS = 2, PLANES = 2, BT = 3, AW = 14, ROW_W = 1;
   localparam int FRAME_WORDS = COLS * ROWS * PLANES;

   logic clk = 1'b0;
   logic reset_n, enable;
   logic [AW-1:0] base_addr, mem_address;
   logic mem_read, mem_waitrequest, mem_readdatavalid;
   logic [15:0] mem_readdata;
   logic [5:0] led_rgb;
   logic led_clk, led_lat, led_oe_n, frame_done;
   logic [ROW_W-1:0] led_row;

   always #5 clk = ~clk;

   led_tile_scan_driver #(.COLS(COLS), .ROWS(ROWS), .PLANES(PLANES), .BASE_TICKS(BT), .ADDR_W(AW)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .base_addr(base_addr),
      .mem_address(mem_address), .mem_read(mem_read), .mem_waitrequest(mem_waitrequest),
      .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
      .led_rgb(led_rgb), .led_clk(led_clk), .led_lat(led_lat), .led_oe_n(led_oe_n),
      .led_row(led_row), .frame_done(frame_done));

   logic [15:0] mem [0:16383];
   int checks = 0, failures = 0;

   logic [AW-1:0] exp_addr_q[$];
   logic [5:0]    exp_rgb_q[$];
   int            exp_oe_q[$], exp_row_q[$], fd_memread_q[$];
   int rises, row_rises, fd_count, oe_run, stall_seen, stall_bad, shift_oe_bad;
   int req_num, stall_idx, wait_cnt;
   bit req_active, pend;
   logic [15:0] pend_data;
   logic prev_lclk;
   logic [5:0] prev_rgb;
   logic [AW-1:0] stall_addr;

   // Memory model and scoreboard: inputs change on negedge, outputs sampled there too.
   initial begin : mon
      logic [AW-1:0] ea;
      logic [5:0] er;
      int ei;
      mem_waitrequest = 1'b0; mem_readdata = '0; mem_readdatavalid = 1'b0;
      prev_lclk = 1'b0; prev_rgb = '0;
      forever begin
         @(negedge clk);
         mem_readdatavalid = pend;
         mem_readdata      = pend ? pend_data : 16'h0;
         pend = 1'b0;
         if (mem_read) begin
            if (!req_active) begin
               req_active = 1'b1; req_num++;
               if (req_num == stall_idx) begin wait_cnt = 5; stall_addr = mem_address; end
            end
            if (wait_cnt > 0) begin
               mem_waitrequest = 1'b1; wait_cnt--; stall_seen++;
               if (mem_address !== stall_addr) stall_bad++;
            end else begin
               mem_waitrequest = 1'b0; req_active = 1'b0;
               pend = 1'b1; pend_data = mem[mem_address];
               checks++;
               if (exp_addr_q.size() == 0) begin
                  failures++; $display("FAIL sb_addr: unexpected read of %h, want no read", mem_address);
               end else begin
                  ea = exp_addr_q.pop_front();
                  if (mem_address !== ea) begin failures++; $display("FAIL sb_addr: got %h want %h", mem_address, ea); end
               end
            end
         end else begin
            mem_waitrequest = 1'b0;
            if (wait_cnt > 0) begin stall_bad++; wait_cnt = 0; end
            req_active = 1'b0;
         end
         if ((led_clk || mem_read) && !led_oe_n) shift_oe_bad++;
         if (led_clk && !prev_lclk) begin
            rises++; row_rises++;
            checks += 2;
            if (exp_rgb_q.size() == 0) begin
               failures += 2; $display("FAIL sb_rgb: unexpected shift of %h, want none", led_rgb);
            end else begin
               er = exp_rgb_q.pop_front();
               if (led_rgb !== er) begin failures++; $display("FAIL sb_rgb_hi: got %h want %h", led_rgb, er); end
               if (prev_rgb !== er) begin failures++; $display("FAIL sb_rgb_setup: got %h want %h", prev_rgb, er); end
            end
         end
         if (led_lat) begin
            checks += 2;
            if (row_rises !== COLS) begin failures++; $display("FAIL sb_row_shifts: got %0d want %0d", row_rises, COLS); end
            row_rises = 0;
            if (exp_row_q.size() == 0) begin
               failures++; $display("FAIL sb_row: unexpected latch of row %0d", led_row);
            end else begin
               ei = exp_row_q.pop_front();
               if (int'(led_row) !== ei) begin failures++; $display("FAIL sb_row: got %0d want %0d", led_row, ei); end
            end
         end
         if (!reset_n) begin
            oe_run = 0;
         end else if (!led_oe_n) begin
            oe_run++;
         end else if (oe_run > 0) begin
            checks++;
            if (exp_oe_q.size() == 0) begin
               failures++; $display("FAIL sb_oe: unexpected run of %0d, want none", oe_run);
            end else begin
               ei = exp_oe_q.pop_front();
               if (oe_run !== ei) begin failures++; $display("FAIL sb_oe: got %0d want %0d", oe_run, ei); end
            end
            oe_run = 0;
         end
         if (frame_done) begin fd_count++; fd_memread_q.push_back(int'(mem_read)); end
         prev_lclk = led_clk; prev_rgb = led_rgb;
      end
   end

   task automatic clear_logs();
      exp_addr_q.delete(); exp_rgb_q.delete(); exp_oe_q.delete(); exp_row_q.delete(); fd_memread_q.delete();
      rises = 0; row_rises = 0; fd_count = 0; oe_run = 0; stall_seen = 0; stall_bad = 0; shift_oe_bad = 0;
      req_num = 0; stall_idx = 0; wait_cnt = 0; req_active = 1'b0; pend = 1'b0;
   endtask

   task automatic push_frame(input logic [AW-1:0] base);
      logic [AW-1:0] a;
      for (int i = 0; i < FRAME_WORDS; i++) begin
         a = base + AW'(i);
         exp_addr_q.push_back(a);
         exp_rgb_q.push_back(mem[a][5:0]);
      end
      for (int p = 0; p < PLANES; p++)
         for (int r = 0; r < ROWS; r++) begin
            exp_oe_q.push_back(BT << p);
            exp_row_q.push_back(r);
         end
   endtask

   task automatic wait_rises(input int n, output bit timeout);
      timeout = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (rises >= n) begin timeout = 1'b0; break; end
      end
   endtask

   task automatic wait_done(input int n, output bit timeout);
      timeout = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (fd_count >= n) begin timeout = 1'b0; break; end
      end
   endtask

   task automatic test_reset();
      clear_logs();
      enable = 1'b0; base_addr = '0; reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks += 8;
      if (mem_read !== 1'b0)     begin failures++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
      if (mem_address !== '0)    begin failures++; $display("FAIL reset_mem_address: got %h want 0", mem_address); end
      if (led_rgb !== '0)        begin failures++; $display("FAIL reset_led_rgb: got %h want 0", led_rgb); end
      if (led_clk !== 1'b0)      begin failures++; $display("FAIL reset_led_clk: got %b want 0", led_clk); end
      if (led_lat !== 1'b0)      begin failures++; $display("FAIL reset_led_lat: got %b want 0", led_lat); end
      if (led_oe_n !== 1'b1)     begin failures++; $display("FAIL reset_led_oe_n: got %b want 1", led_oe_n); end
      if (led_row !== '0)        begin failures++; $display("FAIL reset_led_row: got %h want 0", led_row); end
      if (frame_done !== 1'b0)   begin failures++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_basic_frame();
      bit to1, to2;
      int busy;
      clear_logs();
      base_addr = 14'h0100;
      push_frame(14'h0100);
      enable = 1'b1;
      wait_rises(COLS + 1, to1);
      enable = 1'b0;
      wait_done(1, to2);
      busy = 0;
      repeat (12) begin @(negedge clk); if (mem_read || !led_oe_n) busy++; end
      checks += 6;
      if (to1 || to2)         begin failures++; $display("FAIL basic_timeout: got %b%b want 00", to1, to2); end
      if (fd_count !== 1)     begin failures++; $display("FAIL basic_frame_done: got %0d want 1", fd_count); end
      if (rises !== FRAME_WORDS) begin failures++; $display("FAIL basic_shifts: got %0d want %0d", rises, FRAME_WORDS); end
      if (busy !== 0)         begin failures++; $display("FAIL basic_idle_after: got %0d busy cycles want 0", busy); end
      if (shift_oe_bad !== 0) begin failures++; $display("FAIL basic_oe_during_shift: got %0d want 0", shift_oe_bad); end
      if (exp_addr_q.size() + exp_rgb_q.size() + exp_oe_q.size() + exp_row_q.size() !== 0) begin
         failures++; $display("FAIL basic_leftover: got %0d pending want 0", exp_addr_q.size() + exp_oe_q.size());
      end
   endtask

   task automatic test_col0_pattern();
      bit to1, to2;
      clear_logs();
      for (int i = 0; i < FRAME_WORDS; i++) mem[14'h0200 + i] = (i % COLS == 0) ? 16'h003F : 16'h0000;
      base_addr = 14'h0200;
      push_frame(14'h0200);
      enable = 1'b1;
      wait_rises(COLS + 1, to1);
      enable = 1'b0;
      wait_done(1, to2);
      repeat (4) @(negedge clk);
      checks += 3;
      if (to1 || to2)         begin failures++; $display("FAIL col0_timeout: got %b%b want 00", to1, to2); end
      if (rises !== FRAME_WORDS) begin failures++; $display("FAIL col0_shifts: got %0d want %0d", rises, FRAME_WORDS); end
      if (exp_rgb_q.size() + exp_row_q.size() !== 0) begin
         failures++; $display("FAIL col0_leftover: got %0d pending want 0", exp_rgb_q.size() + exp_row_q.size());
      end
   endtask

   task automatic test_waitrequest();
      bit to1, to2;
      clear_logs();
      stall_idx = 3;
      base_addr = 14'h0400;
      push_frame(14'h0400);
      enable = 1'b1;
      wait_rises(COLS + 1, to1);
      enable = 1'b0;
      wait_done(1, to2);
      repeat (4) @(negedge clk);
      checks += 5;
      if (to1 || to2)          begin failures++; $display("FAIL stall_timeout: got %b%b want 00", to1, to2); end
      if (stall_seen !== 5)    begin failures++; $display("FAIL stall_cycles: got %0d want 5", stall_seen); end
      if (stall_bad !== 0)     begin failures++; $display("FAIL stall_hold: got %0d unstable cycles want 0", stall_bad); end
      if (rises !== FRAME_WORDS) begin failures++; $display("FAIL stall_shifts: got %0d want %0d", rises, FRAME_WORDS); end
      if (exp_addr_q.size() !== 0) begin failures++; $display("FAIL stall_leftover: got %0d want 0", exp_addr_q.size()); end
   endtask

   task automatic test_wrap();
      bit to1, to2;
      clear_logs();
      base_addr = 14'h3FFC;
      push_frame(14'h3FFC);
      enable = 1'b1;
      wait_rises(COLS + 1, to1);
      enable = 1'b0;
      wait_done(1, to2);
      repeat (4) @(negedge clk);
      checks += 2;
      if (to1 || to2) begin failures++; $display("FAIL wrap_timeout: got %b%b want 00", to1, to2); end
      if (exp_addr_q.size() !== 0) begin failures++; $display("FAIL wrap_leftover: got %0d want 0", exp_addr_q.size()); end
   endtask

   task automatic test_back_to_back();
      bit to1, to2, to3;
      int busy;
      clear_logs();
      base_addr = 14'h0040;
      push_frame(14'h0040);
      push_frame(14'h0080);
      enable = 1'b1;
      wait_rises(3, to1);
      base_addr = 14'h0080;
      wait_done(1, to2);
      wait_rises(FRAME_WORDS + COLS + 1, to3);
      enable = 1'b0;
      wait_done(2, to2);
      busy = 0;
      repeat (12) begin @(negedge clk); if (mem_read || !led_oe_n) busy++; end
      checks += 5;
      if (to1 || to2 || to3) begin failures++; $display("FAIL b2b_timeout: got %b%b%b want 000", to1, to2, to3); end
      if (fd_count !== 2)    begin failures++; $display("FAIL b2b_frame_done: got %0d want 2", fd_count); end
      if (fd_memread_q.size() !== 2 || fd_memread_q[0] !== 1 || fd_memread_q[1] !== 0) begin
         failures++; $display("FAIL b2b_restart: got %0d pulses want 2 with read 1 then 0", fd_memread_q.size());
      end
      if (busy !== 0)        begin failures++; $display("FAIL b2b_idle_after: got %0d want 0", busy); end
      if (exp_addr_q.size() + exp_oe_q.size() !== 0) begin
         failures++; $display("FAIL b2b_leftover: got %0d want 0", exp_addr_q.size() + exp_oe_q.size());
      end
   endtask

   task automatic test_reset_in_display();
      bit found, to1, to2;
      clear_logs();
      base_addr = 14'h0300;
      push_frame(14'h0300);
      enable = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (!led_oe_n) begin found = 1'b1; break; end
      end
      #2 reset_n = 1'b0;
      #1;
      checks += 4;
      if (!found)            begin failures++; $display("FAIL rst_disp_reach: got 0 want 1"); end
      if (led_oe_n !== 1'b1) begin failures++; $display("FAIL rst_disp_oe_n: got %b want 1", led_oe_n); end
      if (led_lat !== 1'b0)  begin failures++; $display("FAIL rst_disp_lat: got %b want 0", led_lat); end
      if (mem_read !== 1'b0) begin failures++; $display("FAIL rst_disp_mem_read: got %b want 0", mem_read); end
      clear_logs();
      push_frame(14'h0300);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      wait_rises(COLS + 1, to1);
      enable = 1'b0;
      wait_done(1, to2);
      repeat (4) @(negedge clk);
      checks += 2;
      if (to1 || to2) begin failures++; $display("FAIL rst_resume_timeout: got %b%b want 00", to1, to2); end
      if (exp_addr_q.size() + exp_row_q.size() !== 0) begin
         failures++; $display("FAIL rst_resume_leftover: got %0d want 0", exp_addr_q.size() + exp_row_q.size());
      end
   endtask

   initial begin
      for (int a = 0; a < 16384; a++) mem[a] = 16'((a * 40503) ^ 32'h0000_A5C3);
      reset_n = 1'b0; enable = 1'b0; base_addr = '0;
      test_reset();
      test_basic_frame();
      test_col0_pattern();
      test_waitrequest();
      test_wrap();
      test_back_to_back();
      test_reset_in_display();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
